izhikevich_array: RTL and testbench

- Time-multiplexed array of N Izhikevich neurons sharing one arithmetic datapath.
- Per-neuron state (v, u) and per-neuron parameters (a, b, c, d, I) live in internal register files and are loaded through a configuration port.
- A `step` pulse advances every neuron by one Euler time step, one neuron per cycle.
- The result is a spike vector plus a done pulse; this is the network-level successor to the single hard-coded neuron.

---
 rtl/izhikevich_array_if.sv | 28 ++
 rtl/izhikevich_array.sv | 140 ++++++++++++++
 tb/tb_izhikevich_array.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/izhikevich_array_if.sv
// izhikevich_array_if: configuration, step control, status and readback bundle for the neuron array.
interface izhikevich_array_if #(
  parameter int N_NEURONS = 4,
  parameter int W = 32
);
  localparam int AW = $clog2(N_NEURONS);
  logic cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [2:0] cfg_sel;
  logic [W-1:0] cfg_data;
  logic cfg_err;
  logic step;
  logic busy;
  logic done;
  logic [N_NEURONS-1:0] spikes;
  logic [15:0] step_count;
  logic [AW-1:0] rd_addr;
  logic [W-1:0] rd_v;
  logic [W-1:0] rd_u;
  modport master (
    output cfg_we, cfg_addr, cfg_sel, cfg_data, step, rd_addr,
    input cfg_err, busy, done, spikes, step_count, rd_v, rd_u
  );
  modport slave (
    input cfg_we, cfg_addr, cfg_sel, cfg_data, step, rd_addr,
    output cfg_err, busy, done, spikes, step_count, rd_v, rd_u
  );
endinterface

// File: rtl/izhikevich_array.sv
// izhikevich_array: N Izhikevich neurons time-multiplexed over one saturating fixed-point Euler datapath.
module izhikevich_array #(
  parameter int N_NEURONS = 4,
  parameter int W = 32,
  parameter int FRAC = 16,
  parameter int DT_SHIFT = 4,
  parameter logic signed [W-1:0] VPEAK = 32'sh001E_0000
) (
  input logic CLOCK_50,
  input logic reset,
  izhikevich_array_if.slave bus
);
  localparam int AW = $clog2(N_NEURONS);
  typedef logic signed [W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam word_t K004 = 32'sh0000_0A3D;
  localparam word_t K140 = word_t'(140 * (1 << FRAC));
  localparam word_t V_RST = 32'shFFBF_0000;
  localparam word_t U_RST = 32'shFFF3_0000;
  localparam word_t A_RST = 32'sh0000_051F;
  localparam word_t B_RST = 32'sh0000_3333;
  localparam word_t D_RST = 32'sh0008_0000;

  function automatic logic signed [W+1:0] ext(input word_t x);
    return $signed({{2{x[W-1]}}, x});
  endfunction

  function automatic word_t sat(input logic signed [W+1:0] x);
    return (&x[W+1:W-1] | ~|x[W+1:W-1]) ? x[W-1:0] : {x[W+1], {(W-1){~x[W+1]}}};
  endfunction

  function automatic word_t add(input word_t x, input word_t y);
    return sat(ext(x) + ext(y));
  endfunction

  function automatic word_t sub(input word_t x, input word_t y);
    return sat(ext(x) - ext(y));
  endfunction

  function automatic word_t mul(input word_t x, input word_t y);
    logic signed [2*W-1:0] p;
    p = (x * y) >>> FRAC;
    return (&p[2*W-1:W-1] | ~|p[2*W-1:W-1]) ? p[W-1:0] : {p[2*W-1], {(W-1){~p[2*W-1]}}};
  endfunction

  word_t v_mem [N_NEURONS];
  word_t u_mem [N_NEURONS];
  word_t a_mem [N_NEURONS];
  word_t b_mem [N_NEURONS];
  word_t c_mem [N_NEURONS];
  word_t d_mem [N_NEURONS];
  word_t i_mem [N_NEURONS];
  state_t state;
  logic [AW-1:0] idx;
  logic [N_NEURONS-1:0] shadow;
  logic [N_NEURONS-1:0] spikes;
  logic [15:0] step_count;
  logic busy, done, cfg_err, fire;
  word_t v, u, dv, du, v_next, u_next;

  // Spike test uses the pre-update v; a spiking neuron bypasses the Euler result.
  always_comb begin
    v = v_mem[idx];
    u = u_mem[idx];
    fire = v >= VPEAK;
    dv = add(sub(add(add(mul(K004, mul(v, v)), add(sat(ext(v) <<< 2), v)), K140), u), i_mem[idx]);
    du = mul(a_mem[idx], sub(mul(b_mem[idx], v), u));
    v_next = fire ? c_mem[idx] : add(v, dv >>> DT_SHIFT);
    u_next = add(u, fire ? d_mem[idx] : du >>> DT_SHIFT);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_RST;
        u_mem[k] <= U_RST;
        a_mem[k] <= A_RST;
        b_mem[k] <= B_RST;
        c_mem[k] <= V_RST;
        d_mem[k] <= D_RST;
        i_mem[k] <= '0;
      end
      state <= IDLE;
      idx <= '0;
      shadow <= '0;
      spikes <= '0;
      step_count <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done <= 1'b0;
      cfg_err <= bus.cfg_we && state != IDLE;
      case (state)
        IDLE: begin
          if (bus.cfg_we)
            case (bus.cfg_sel)
              3'd0: a_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd1: b_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd2: c_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd3: d_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd4: i_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd5: v_mem[bus.cfg_addr] <= bus.cfg_data;
              3'd6: u_mem[bus.cfg_addr] <= bus.cfg_data;
              default: ;
            endcase
          if (bus.step) begin
            state <= RUN;
            idx <= '0;
            busy <= 1'b1;
          end
        end
        RUN: begin
          v_mem[idx] <= v_next;
          u_mem[idx] <= u_next;
          shadow[idx] <= fire;
          idx <= idx + AW'(1);
          if (&idx) begin
            state <= DONE;
            busy <= 1'b0;
          end
        end
        default: begin
          done <= 1'b1;
          spikes <= shadow;
          step_count <= step_count + 16'd1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cfg_err = cfg_err;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.spikes = spikes;
  assign bus.step_count = step_count;
  assign bus.rd_v = v_mem[bus.rd_addr];
  assign bus.rd_u = u_mem[bus.rd_addr];
endmodule

// File: tb/tb_izhikevich_array.sv
// tb_izhikevich_array: directed vectors with hand-computed fixed-point results for izhikevich_array.
module tb_izhikevich_array;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  izhikevich_array_if bus ();
  izhikevich_array dut (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus));

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic peek(input int n, input logic [31:0] ev, input logic [31:0] eu, input bit chk_u = 1'b1);
    bus.rd_addr = 2'(n);
    #1;
    check($sformatf("rd_v[%0d]", n), bus.rd_v, ev);
    if (chk_u) check($sformatf("rd_u[%0d]", n), bus.rd_u, eu);
  endtask

  task automatic cfg(input int n, input int sel, input logic [31:0] val);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'(n);
    bus.cfg_sel = 3'(sel);
    bus.cfg_data = val;
    @(negedge CLOCK_50);
    bus.cfg_we = 1'b0;
  endtask

  // Any cfg signals already driven ride along with the step request.
  task automatic run_step(input logic [3:0] exp_spk, input int exp_cnt);
    int lat, busy_n;
    lat = 0;
    busy_n = 0;
    bus.step = 1'b1;
    @(negedge CLOCK_50);
    bus.step = 1'b0;
    bus.cfg_we = 1'b0;
    for (int i = 0; i < 12 && !bus.done; i++) begin
      busy_n += int'(bus.busy);
      @(negedge CLOCK_50);
      lat++;
    end
    check("done_latency", lat, 5);
    check("busy_cycles", busy_n, 4);
    check("spikes", bus.spikes, exp_spk);
    check("step_count", bus.step_count, exp_cnt);
    @(negedge CLOCK_50);
    check("done_pulse_width", bus.done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_sel = '0;
    bus.cfg_data = '0;
    bus.step = 1'b0;
    bus.rd_addr = '0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_cfg_err", bus.cfg_err, 1'b0);
    check("rst_spikes", bus.spikes, 4'b0000);
    check("rst_step_count", bus.step_count, 0);
    for (int n = 0; n < 4; n++) peek(n, 32'hFFBF_0000, 32'hFFF3_0000);

    // Default parameters: v = -65 -> -65.1893, u stays -13 exactly.
    run_step(4'b0000, 1);
    for (int n = 0; n < 4; n++) peek(n, 32'hFFBE_CF8B, 32'hFFF3_0000);

    // Write coincident with step: v[2] = 31.0 must be used by this step.
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd2;
    bus.cfg_sel = 3'd5;
    bus.cfg_data = 32'h001F_0000;
    run_step(4'b0100, 2);
    peek(2, 32'hFFBF_0000, 32'hFFFB_0000);

    // Exactly VPEAK fires, one LSB below does not.
    cfg(1, 5, 32'h001E_0000);
    cfg(0, 5, 32'h001D_FFFF);
    run_step(4'b0010, 3);
    peek(1, 32'hFFBF_0000, 32'h0, 1'b0);

    // Saturated input current; neuron 0 (now ~51) fires this step.
    cfg(3, 4, 32'h7FFF_FFFF);
    cfg(3, 5, 32'h0000_0000);
    cfg(3, 6, 32'hFFF3_0000);
    cfg(3, 7, 32'h1234_5678);
    run_step(4'b0001, 4);
    peek(3, 32'h07FF_FFFF, 32'hFFF3_0429);
    run_step(4'b1000, 5);
    peek(3, 32'hFFBF_0000, 32'hFFFB_0429);

    // Writes and step requests while the array is stepping are dropped.
    cfg(2, 5, 32'h001E_0000);
    cfg(2, 6, 32'hFFF3_0000);
    bus.step = 1'b1;
    @(negedge CLOCK_50);
    bus.step = 1'b0;
    @(negedge CLOCK_50);
    bus.step = 1'b1;
    @(negedge CLOCK_50);
    bus.step = 1'b0;
    @(negedge CLOCK_50);
    check("busy_last_run_cycle", bus.busy, 1'b1);
    bus.cfg_we = 1'b1;
    bus.cfg_addr = 2'd2;
    bus.cfg_sel = 3'd5;
    bus.cfg_data = 32'h0001_0000;
    @(negedge CLOCK_50);
    check("cfg_err_in_run", bus.cfg_err, 1'b1);
    bus.cfg_sel = 3'd6;
    bus.cfg_data = 32'h0000_0000;
    @(negedge CLOCK_50);
    check("cfg_err_in_done", bus.cfg_err, 1'b1);
    check("done_abnormal", bus.done, 1'b1);
    bus.cfg_we = 1'b0;
    @(negedge CLOCK_50);
    check("cfg_err_clear", bus.cfg_err, 1'b0);
    check("no_queued_step", bus.busy, 1'b0);
    check("step_count_once", bus.step_count, 6);
    check("spikes_abnormal", bus.spikes, 4'b0100);
    peek(2, 32'hFFBF_0000, 32'hFFFB_0000);
    @(negedge CLOCK_50);
    check("still_idle", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a run.
    bus.step = 1'b1;
    @(negedge CLOCK_50);
    bus.step = 1'b0;
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    check("midrun_busy", bus.busy, 1'b0);
    check("midrun_step_count", bus.step_count, 0);
    check("midrun_spikes", bus.spikes, 4'b0000);
    for (int n = 0; n < 4; n++) peek(n, 32'hFFBF_0000, 32'hFFF3_0000);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    run_step(4'b0000, 1);
    for (int n = 0; n < 4; n++) peek(n, 32'hFFBE_CF8B, 32'hFFF3_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
